// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO plus 8N1 serialiser for the j1 byte-output port.
// The CPU cannot be stalled, so a strobe that finds the FIFO full is dropped
// and latched in the sticky overflow flag.
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (tx low)
// DATA  | eight data bits, LSB first
// STOP  | stop bit (tx high); pops the next byte straight into START
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic [7:0] d_in,
  input  logic       d_in_start,
  input  logic       overflow_clr,
  output logic       tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int BW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_nxt;
  logic [BW-1:0]      baud;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               fifo_empty;
  logic               baud_done;
  logic               frame_slot;
  logic               pop;
  logic               push;
  logic               going_idle;

  // FIFO handshake: a pop on the same edge frees the slot a full-FIFO push needs
  always_comb begin
    fifo_empty = (count == '0);
    baud_done  = (baud == BAUD_LAST);
    frame_slot = (state == IDLE) || ((state == STOP) && baud_done);
    pop        = frame_slot && !fifo_empty;
    going_idle = frame_slot && fifo_empty;
    push       = d_in_start && ((count != COUNT_FULL) || pop);
    count_nxt  = count + CW'(push) - CW'(pop);
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= d_in;
  end

  // FIFO pointers, count, status flags derived from post-edge state
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      busy      <= 1'b0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      count     <= count_nxt;
      busy      <= !going_idle || (count_nxt != '0);
      fifo_full <= (count_nxt == COUNT_FULL);
      if (d_in_start && !push) overflow <= 1'b1;
      else if (overflow_clr)   overflow <= 1'b0;
    end
  end

  // Serialiser FSM; tx is registered so it changes on the edge that enters a bit
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          baud  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with 4 clocks per bit and a 4-deep FIFO.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       resetq;
  logic [7:0] d_in;
  logic       d_in_start;
  logic       overflow_clr;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] rx_q [$];
  int         rx_t [$];

  typedef struct {
    logic       strobe;
    logic [7:0] din;
    logic       clr;
    logic       exp_tx;
    logic       exp_busy;
    logic       busy_care;
    logic       exp_full;
    logic       exp_ovf;
  } vec_t;

  vec_t vt [42];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
    .clk          (clk),
    .resetq       (resetq),
    .d_in         (d_in),
    .d_in_start   (d_in_start),
    .overflow_clr (overflow_clr),
    .tx           (tx),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bench-side receiver: decodes 8N1 frames from tx, records byte and start cycle
  logic       rx_active = 1'b0;
  int         rx_start  = 0;
  logic [7:0] rx_byte   = 8'h00;
  always @(posedge clk) begin
    int c;
    #1;
    cyc++;
    if (!resetq) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx == 1'b0) begin
        rx_active = 1'b1;
        rx_start  = cyc;
        rx_byte   = 8'h00;
      end
    end else begin
      c = cyc - rx_start;
      if (c >= 4 && c < 36 && (c % 4) == 2) rx_byte[(c - 4) / 4] = tx;
      if (c == 38) begin
        check("stop_bit", {31'd0, tx}, 32'd1);
        rx_q.push_back(rx_byte);
        rx_t.push_back(rx_start);
      end
      if (c == 39) rx_active = 1'b0;
    end
  end

  task automatic wait_frames(input int n, input int budget, input string name);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    repeat (2) tick();
    rx_q.delete();
    rx_t.delete();
  endtask

  task automatic wait_start(input int budget);
    int k = 0;
    do begin
      tick();
      k++;
    end while (tx !== 1'b0 && k < budget);
    check("start_timeout", {31'd0, tx}, 32'd0);
  endtask

  task automatic strobe(input logic [7:0] b);
    d_in       = b;
    d_in_start = 1'b1;
    tick();
    d_in_start = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] exp3 [5];
    logic [7:0] exp5 [6];
    int lows;

    d_in = 8'h00;
    d_in_start = 1'b0;
    overflow_clr = 1'b0;
    resetq = 1'b0;
    repeat (3) tick();
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_full", {31'd0, fifo_full}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    resetq = 1'b1;
    repeat (3) tick();

    // single 0x55 frame, cycle by cycle
    pat = 8'h55;
    for (int i = 0; i < 42; i++) begin
      vt[i].strobe    = (i == 0);
      vt[i].din       = (i == 0) ? 8'h55 : 8'h00;
      vt[i].clr       = 1'b0;
      if (i == 0)       vt[i].exp_tx = 1'b1;
      else if (i <= 4)  vt[i].exp_tx = 1'b0;
      else if (i <= 36) vt[i].exp_tx = pat[(i - 5) / 4];
      else              vt[i].exp_tx = 1'b1;
      vt[i].exp_busy  = (i <= 40);
      vt[i].busy_care = (i != 0);
      vt[i].exp_full  = 1'b0;
      vt[i].exp_ovf   = 1'b0;
    end
    for (int i = 0; i < 42; i++) begin
      d_in         = vt[i].din;
      d_in_start   = vt[i].strobe;
      overflow_clr = vt[i].clr;
      tick();
      d_in_start   = 1'b0;
      overflow_clr = 1'b0;
      check($sformatf("t1_tx[%0d]", i), {31'd0, tx}, {31'd0, vt[i].exp_tx});
      if (vt[i].busy_care) check($sformatf("t1_busy[%0d]", i), {31'd0, busy}, {31'd0, vt[i].exp_busy});
      check($sformatf("t1_full[%0d]", i), {31'd0, fifo_full}, {31'd0, vt[i].exp_full});
      check($sformatf("t1_ovf[%0d]", i), {31'd0, overflow}, {31'd0, vt[i].exp_ovf});
    end
    wait_frames(1, 10, "t1_frames");
    if (rx_q.size() >= 1) check("t1_byte", rx_q[0], 8'h55);
    wait_idle(100);

    // strobe held 3 cycles -> three back-to-back frames
    d_in_start = 1'b1;
    d_in = 8'h41; tick();
    d_in = 8'h42; tick();
    d_in = 8'h43; tick();
    d_in_start = 1'b0;
    wait_frames(3, 200, "t2_frames");
    if (rx_q.size() >= 3) begin
      check("t2_b0", rx_q[0], 8'h41);
      check("t2_b1", rx_q[1], 8'h42);
      check("t2_b2", rx_q[2], 8'h43);
      check("t2_gap01", rx_t[1] - rx_t[0], FRAME);
      check("t2_gap12", rx_t[2] - rx_t[1], FRAME);
    end
    check("t2_ovf", {31'd0, overflow}, 32'd0);
    wait_idle(100);

    // overflow: 4 stored, 5th dropped; clear racing a drop keeps the flag
    strobe(8'h01);
    wait_start(10);
    for (int j = 0; j < 5; j++) begin
      strobe(8'h10 + 8'(j));
      check($sformatf("t3_full[%0d]", j), {31'd0, fifo_full}, {31'd0, (j >= 3)});
      check($sformatf("t3_ovf[%0d]", j), {31'd0, overflow}, {31'd0, (j == 4)});
    end
    d_in = 8'h99;
    d_in_start = 1'b1;
    overflow_clr = 1'b1;
    tick();
    d_in_start = 1'b0;
    overflow_clr = 1'b0;
    check("t6_ovf_set_wins", {31'd0, overflow}, 32'd1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("t3_ovf_clr", {31'd0, overflow}, 32'd0);
    exp3 = '{8'h01, 8'h10, 8'h11, 8'h12, 8'h13};
    wait_frames(5, 300, "t3_frames");
    if (rx_q.size() >= 5)
      for (int j = 0; j < 5; j++) check($sformatf("t3_b%0d", j), rx_q[j], exp3[j]);
    wait_idle(100);

    // full FIFO, strobe lands on the STOP->START pop edge
    strobe(8'hA0);
    wait_start(10);
    for (int j = 0; j < 4; j++) strobe(8'hB0 + 8'(j));
    check("t5_full", {31'd0, fifo_full}, 32'd1);
    repeat (FRAME - 5) tick();
    strobe(8'h77);
    check("t5_full_after", {31'd0, fifo_full}, 32'd1);
    check("t5_ovf", {31'd0, overflow}, 32'd0);
    exp5 = '{8'hA0, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h77};
    wait_frames(6, 350, "t5_frames");
    if (rx_q.size() >= 6)
      for (int j = 0; j < 6; j++) check($sformatf("t5_b%0d", j), rx_q[j], exp5[j]);
    check("t5_ovf_end", {31'd0, overflow}, 32'd0);
    wait_idle(100);

    // async reset during data bit 3 of 0xA5 with two bytes queued
    strobe(8'hA5);
    wait_start(10);
    strobe(8'hC1);
    strobe(8'hC2);
    repeat (15) tick();
    #3;
    resetq = 1'b0;
    #1;
    check("t4_tx", {31'd0, tx}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_full", {31'd0, fifo_full}, 32'd0);
    repeat (3) tick();
    resetq = 1'b1;
    rx_q.delete();
    rx_t.delete();
    lows = 0;
    for (int j = 0; j < 100; j++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check("t4_tx_lows", lows, 0);
    check("t4_no_frames", rx_q.size(), 0);
    check("t4_busy_after", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
